// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared types and defaults for the reaction-timer responder
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    PRESS   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int TICK_DIV_50MHZ  = 500000;
  localparam int PRESS_TICKS_DEF = 10;

  function automatic logic is_busy(state_t s);
    return (s == DELAY) || (s == PRESS) || (s == RELEASE);
  endfunction

endpackage

// File: rtl/reaction_responder_tick_divider.sv
// rtl/reaction_responder_tick_divider.sv - 0.01 s tick pulse generator with restart
module tick_divider #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic key0,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!key0) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/reaction_responder.sv
// rtl/reaction_responder.sv - presses the reaction key a programmed delay after the stimulus LED lights
module reaction_responder
  import reaction_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_50MHZ,
  parameter int PRESS_TICKS = PRESS_TICKS_DEF,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             key0,
  input  logic             enable,
  input  logic             led_in,
  input  logic [7:0]       delay_sw,
  output logic             key3_out,
  output logic             busy,
  output logic [CNT_W-1:0] resp_count,
  output logic [CNT_W-1:0] abort_count
);

  localparam logic [7:0]       PRESS_LAST = 8'(PRESS_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t     state, state_nx;
  logic       sync1, led_s, led_prev;
  logic       rise, fall, tick, clr;
  logic [7:0] tick_cnt, d_lat, d_lat_nx;
  logic       resp_inc, abort_inc;

  assign rise = led_s & ~led_prev;
  assign fall = ~led_s & led_prev;
  // Restarting the divider on every transition makes each interval start at state entry.
  assign clr  = (state_nx != state);

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .key0 (key0),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!key0) begin
      sync1       <= 1'b1;
      led_s       <= 1'b1;
      led_prev    <= 1'b1;
      state       <= IDLE;
      key3_out    <= 1'b1;
      busy        <= 1'b0;
      tick_cnt    <= '0;
      d_lat       <= '0;
      resp_count  <= '0;
      abort_count <= '0;
    end else begin
      sync1    <= led_in;
      led_s    <= sync1;
      led_prev <= led_s;
      state    <= state_nx;
      key3_out <= (state_nx != PRESS);
      busy     <= is_busy(state_nx);
      d_lat    <= d_lat_nx;
      if (clr) begin
        tick_cnt <= '0;
      end else if (tick && (state == DELAY || state == PRESS)) begin
        tick_cnt <= tick_cnt + 8'd1;
      end
      if (resp_inc && resp_count != CNT_MAX) begin
        resp_count <= resp_count + 1'b1;
      end
      if (abort_inc && abort_count != CNT_MAX) begin
        abort_count <= abort_count + 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    d_lat_nx  = d_lat;
    resp_inc  = 1'b0;
    abort_inc = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: state_nx = ARMED;
        ARMED: begin
          if (rise) begin
            d_lat_nx = delay_sw;
            state_nx = (delay_sw == 8'd0) ? PRESS : DELAY;
          end
        end
        DELAY: begin
          // A falling LED beats a coinciding final tick.
          if (fall) begin
            abort_inc = 1'b1;
            state_nx  = ARMED;
          end else if (tick && tick_cnt == d_lat - 8'd1) begin
            state_nx = PRESS;
          end
        end
        PRESS: begin
          if (tick && tick_cnt == PRESS_LAST) begin
            resp_inc = 1'b1;
            state_nx = RELEASE;
          end
        end
        RELEASE: begin
          if (!led_s) state_nx = ARMED;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_responder.sv
// tb/tb_reaction_responder.sv - directed self-checking bench for reaction_responder
module tb_reaction_responder;

  logic       clk = 1'b0;
  logic       key0, enable, led_in;
  logic [7:0] delay_sw;
  logic       key3_out, busy;
  logic [7:0] resp_count, abort_count;

  int checks   = 0;
  int failures = 0;

  reaction_responder #(.TICK_DIV(4), .PRESS_TICKS(2), .CNT_W(8)) dut (
    .clk         (clk),
    .key0        (key0),
    .enable      (enable),
    .led_in      (led_in),
    .delay_sw    (delay_sw),
    .key3_out    (key3_out),
    .busy        (busy),
    .resp_count  (resp_count),
    .abort_count (abort_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Posedges after the current point until key3_out reads low; -1 on timeout.
  task automatic wait_low(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc(1);
      if (key3_out == 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  // Called on the first low sample; returns how many samples key3_out stayed low.
  task automatic low_width(output int w);
    w = 1;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (key3_out == 1'b1) break;
      w++;
    end
  endtask

  task automatic count_lows(input int span, output int lows);
    lows = 0;
    for (int i = 0; i < span; i++) begin
      cyc(1);
      if (key3_out == 1'b0) lows++;
    end
  endtask

  task automatic do_response();
    led_in = 1'b1;
    cyc(14);
    led_in = 1'b0;
    cyc(5);
  endtask

  int n, w, lows;

  initial begin
    key0 = 1'b0; enable = 1'b0; led_in = 1'b0; delay_sw = 8'd0;
    cyc(3);
    check_eq("reset_key3", key3_out, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_resp", resp_count, 0);
    check_eq("reset_abort", abort_count, 0);
    key0 = 1'b1;
    cyc(3);
    enable = 1'b1;
    cyc(2);

    // delay 5: low at E+21 (E is two posedges after the LED drive), 8 cycles wide
    delay_sw = 8'd5;
    led_in = 1'b1;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      cyc(1);
      if (i == 2) check_eq("d5_busy_before", busy, 0);
      if (i == 3) check_eq("d5_busy_after", busy, 1);
      if (i == 5) delay_sw = 8'd0;
      if (key3_out == 1'b0) begin
        n = i;
        break;
      end
    end
    check_eq("d5_latency", n, 23);
    low_width(w);
    check_eq("d5_width", w, 8);
    check_eq("d5_resp", resp_count, 1);
    check_eq("d5_busy_release", busy, 1);
    led_in = 1'b0;
    cyc(5);
    check_eq("d5_busy_armed", busy, 0);

    // delay 0: press on E+1
    delay_sw = 8'd0;
    led_in = 1'b1;
    wait_low(50, n);
    check_eq("d0_latency", n, 3);
    low_width(w);
    check_eq("d0_width", w, 8);
    check_eq("d0_resp", resp_count, 2);
    led_in = 1'b0;
    cyc(5);

    // LED drops during a 10-tick delay: abort, then a fresh rise still works
    delay_sw = 8'd10;
    led_in = 1'b1;
    cyc(14);
    led_in = 1'b0;
    count_lows(60, lows);
    check_eq("abort_no_press", lows, 0);
    check_eq("abort_count", abort_count, 1);
    check_eq("abort_resp", resp_count, 2);
    check_eq("abort_busy", busy, 0);
    delay_sw = 8'd2;
    led_in = 1'b1;
    wait_low(80, n);
    check_eq("rearm_latency", n, 11);
    low_width(w);
    check_eq("rearm_width", w, 8);
    check_eq("rearm_resp", resp_count, 3);
    led_in = 1'b0;
    cyc(5);

    // LED already lit when armed: needs a new edge
    enable = 1'b0;
    cyc(2);
    led_in = 1'b1;
    cyc(4);
    enable = 1'b1;
    count_lows(30, lows);
    check_eq("prelit_no_press", lows, 0);
    led_in = 1'b0;
    cyc(4);
    delay_sw = 8'd0;
    led_in = 1'b1;
    wait_low(50, n);
    check_eq("prelit_latency", n, 3);
    low_width(w);
    check_eq("prelit_resp", resp_count, 4);
    led_in = 1'b0;
    cyc(5);

    // disable mid-press
    led_in = 1'b1;
    wait_low(50, n);
    check_eq("dis_latency", n, 3);
    cyc(2);
    check_eq("dis_still_low", key3_out, 0);
    enable = 1'b0;
    cyc(1);
    check_eq("dis_key3", key3_out, 1);
    check_eq("dis_busy", busy, 0);
    check_eq("dis_resp", resp_count, 4);
    led_in = 1'b0;
    enable = 1'b1;
    cyc(5);

    // reset mid-delay
    delay_sw = 8'd5;
    led_in = 1'b1;
    cyc(6);
    check_eq("rst_in_delay_busy", busy, 1);
    key0 = 1'b0;
    cyc(1);
    check_eq("rst_key3", key3_out, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_resp", resp_count, 0);
    check_eq("rst_abort", abort_count, 0);
    key0 = 1'b1;
    led_in = 1'b0;
    cyc(4);

    // saturation
    delay_sw = 8'd0;
    for (int i = 0; i < 255; i++) do_response();
    check_eq("sat_resp_255", resp_count, 255);
    do_response();
    check_eq("sat_resp_hold", resp_count, 255);
    check_eq("sat_abort", abort_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
